// File: rtl/array_arbiter.sv
// Round-robin front end sharing one combinational array unit between NREQ requesters.
// Two-stage pipeline: S1 registers the granted command, S2 captures the array result.
module array_arbiter #(
   parameter int unsigned UNIT_SIZE = 32,
   parameter int unsigned NREQ      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NREQ-1:0]               i_req_valid,
   output logic [NREQ-1:0]               o_req_ready,
   input  logic [2*NREQ-1:0]             i_req_opcode,
   input  logic [NREQ*5*UNIT_SIZE-1:0]   i_req_in1,
   input  logic [NREQ*5*UNIT_SIZE-1:0]   i_req_in2,
   output logic [NREQ-1:0]               o_rsp_valid,
   input  logic [NREQ-1:0]               i_rsp_ready,
   output logic [5*UNIT_SIZE-1:0]        o_rsp_res,
   output logic [1:0]                    o_arr_opcode,
   output logic [5*UNIT_SIZE-1:0]        o_arr_in1,
   output logic [5*UNIT_SIZE-1:0]        o_arr_in2,
   input  logic [5*UNIT_SIZE-1:0]        i_arr_res,
   output logic                          o_busy
);

   localparam int unsigned DW  = 5 * UNIT_SIZE;
   localparam int unsigned IDW = $clog2(NREQ);

   logic              s1_valid_q, s1_valid_d;
   logic [IDW-1:0]    s1_id_q,    s1_id_d;
   logic [1:0]        s1_op_q,    s1_op_d;
   logic [DW-1:0]     s1_in1_q,   s1_in1_d;
   logic [DW-1:0]     s1_in2_q,   s1_in2_d;
   logic              s2_valid_q, s2_valid_d;
   logic [IDW-1:0]    s2_id_q,    s2_id_d;
   logic [DW-1:0]     s2_res_q,   s2_res_d;
   logic [IDW-1:0]    last_q,     last_d;

   logic              s2_fire;
   logic              s2_en;
   logic              s1_en;
   logic              gnt_found;
   logic [IDW-1:0]    gnt_id;
   logic [1:0]        gnt_op;
   logic [DW-1:0]     gnt_in1;
   logic [DW-1:0]     gnt_in2;

   // Pipeline advance: S2 drains to its owner, S1 moves up whenever S2 frees.
   always_comb begin
      s2_fire = s2_valid_q & i_rsp_ready[s2_id_q];
      s2_en   = ~s2_valid_q | s2_fire;
      s1_en   = ~s1_valid_q | s2_en;
   end

   // First valid requester after the last winner, wrapping around.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         if (!gnt_found && i_req_valid[IDW'((32'(last_q) + k) % NREQ)]) begin
            gnt_found = 1'b1;
            gnt_id    = IDW'((32'(last_q) + k) % NREQ);
         end
      end
   end

   // Select the winner's command payload.
   always_comb begin
      gnt_op  = '0;
      gnt_in1 = '0;
      gnt_in2 = '0;
      for (int unsigned r = 0; r < NREQ; r++) begin
         if (gnt_id == IDW'(r)) begin
            gnt_op  = i_req_opcode[2*r +: 2];
            gnt_in1 = i_req_in1[r*DW +: DW];
            gnt_in2 = i_req_in2[r*DW +: DW];
         end
      end
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_id_d     = s1_id_q;
      s1_op_d     = s1_op_q;
      s1_in1_d    = s1_in1_q;
      s1_in2_d    = s1_in2_q;
      s2_valid_d  = s2_valid_q;
      s2_id_d     = s2_id_q;
      s2_res_d    = s2_res_q;
      last_d      = last_q;
      o_req_ready = '0;

      if (s1_en) begin
         s1_valid_d = gnt_found;
         if (gnt_found) begin
            s1_id_d     = gnt_id;
            s1_op_d     = gnt_op;
            s1_in1_d    = gnt_in1;
            s1_in2_d    = gnt_in2;
            last_d      = gnt_id;
            o_req_ready = NREQ'(1) << gnt_id;
         end
      end

      if (s2_en) begin
         s2_valid_d = s1_valid_q;
         s2_id_d    = s1_id_q;
         s2_res_d   = i_arr_res;
      end
   end

   // Reset discards in-flight work and re-arms the pointer so requester 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_id_q    <= '0;
         s1_op_q    <= '0;
         s1_in1_q   <= '0;
         s1_in2_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_id_q    <= '0;
         s2_res_q   <= '0;
         last_q     <= IDW'(NREQ - 1);
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_id_q    <= s1_id_d;
         s1_op_q    <= s1_op_d;
         s1_in1_q   <= s1_in1_d;
         s1_in2_q   <= s1_in2_d;
         s2_valid_q <= s2_valid_d;
         s2_id_q    <= s2_id_d;
         s2_res_q   <= s2_res_d;
         last_q     <= last_d;
      end
   end

   assign o_arr_opcode = s1_op_q;
   assign o_arr_in1    = s1_in1_q;
   assign o_arr_in2    = s1_in2_q;
   assign o_rsp_res    = s2_res_q;
   assign o_rsp_valid  = s2_valid_q ? (NREQ'(1) << s2_id_q) : '0;
   assign o_busy       = s1_valid_q | s2_valid_q;

`ifndef SYNTHESIS
   a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(o_req_ready));
   a_grant_valid  : assert property (@(posedge clk) disable iff (rst) (o_req_ready & ~i_req_valid) == '0);
   a_rsp_onehot   : assert property (@(posedge clk) disable iff (rst) $onehot0(o_rsp_valid));
`endif

endmodule

// File: tb/tb_array_arbiter.sv
// Bench for array_arbiter: vector table, directed corner sequences and a random run
// checked against a queue-based model of the two-deep pipeline.
module tb_array_arbiter;

   localparam int unsigned UNIT_SIZE = 32;
   localparam int unsigned NREQ      = 4;
   localparam int unsigned DW        = 5 * UNIT_SIZE;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       i_req_valid;
   logic [NREQ-1:0]       o_req_ready;
   logic [2*NREQ-1:0]     i_req_opcode;
   logic [NREQ*DW-1:0]    i_req_in1;
   logic [NREQ*DW-1:0]    i_req_in2;
   logic [NREQ-1:0]       o_rsp_valid;
   logic [NREQ-1:0]       i_rsp_ready;
   logic [DW-1:0]         o_rsp_res;
   logic [1:0]            o_arr_opcode;
   logic [DW-1:0]         o_arr_in1;
   logic [DW-1:0]         o_arr_in2;
   logic [DW-1:0]         i_arr_res;
   logic                  o_busy;

   logic [1:0]            op_r  [NREQ];
   logic [UNIT_SIZE-1:0]  in1_r [NREQ][5];
   logic [UNIT_SIZE-1:0]  in2_r [NREQ][5];

   int n_checks = 0;
   int n_errors = 0;

   array_arbiter #(.UNIT_SIZE(UNIT_SIZE), .NREQ(NREQ)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_opcode(i_req_opcode), .i_req_in1(i_req_in1), .i_req_in2(i_req_in2),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_res(o_rsp_res),
      .o_arr_opcode(o_arr_opcode), .o_arr_in1(o_arr_in1), .o_arr_in2(o_arr_in2),
      .i_arr_res(i_arr_res), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   // Stand-in array unit: add, sub, and a 3-row circulant matmul for opcodes 2/3.
   function automatic logic [DW-1:0] arr_fn(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
      logic [UNIT_SIZE-1:0] wa [5];
      logic [UNIT_SIZE-1:0] wb [5];
      logic [UNIT_SIZE-1:0] wr [5];
      logic [UNIT_SIZE-1:0] acc;
      logic [DW-1:0]        r;
      for (int k = 0; k < 5; k++) begin
         wa[k] = a[k*UNIT_SIZE +: UNIT_SIZE];
         wb[k] = b[k*UNIT_SIZE +: UNIT_SIZE];
         wr[k] = '0;
      end
      if (op == 2'd0) begin
         for (int k = 0; k < 5; k++) wr[k] = wa[k] + wb[k];
      end else if (op == 2'd1) begin
         for (int k = 0; k < 5; k++) wr[k] = wa[k] - wb[k];
      end else begin
         for (int k = 0; k < 3; k++) begin
            acc = '0;
            for (int j = 0; j < 3; j++) acc = acc + wa[(k + j) % 5] * wb[j];
            wr[k] = acc;
         end
      end
      r = '0;
      for (int k = 0; k < 5; k++) r[k*UNIT_SIZE +: UNIT_SIZE] = wr[k];
      return r;
   endfunction

   always_comb i_arr_res = arr_fn(o_arr_opcode, o_arr_in1, o_arr_in2);

   always_comb begin
      i_req_opcode = '0;
      i_req_in1    = '0;
      i_req_in2    = '0;
      for (int r = 0; r < NREQ; r++) begin
         i_req_opcode[2*r +: 2] = op_r[r];
         for (int k = 0; k < 5; k++) begin
            i_req_in1[(r*5 + k)*UNIT_SIZE +: UNIT_SIZE] = in1_r[r][k];
            i_req_in2[(r*5 + k)*UNIT_SIZE +: UNIT_SIZE] = in2_r[r][k];
         end
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: in-flight commands in order; an entry is visible once it reaches the output.
   typedef struct {
      int            id;
      logic [DW-1:0] res;
      bit            vis;
   } ent_t;

   ent_t            q [$];
   int              last_m = NREQ - 1;
   logic [NREQ-1:0] acc_vec;

   function automatic logic [NREQ-1:0] model_grant();
      int n;
      bit fire;
      int idx;
      n    = q.size();
      fire = (n > 0) && q[0].vis && i_rsp_ready[q[0].id];
      if (n - int'(fire) >= 2) return '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (last_m + k) % NREQ;
         if (i_req_valid[idx]) return NREQ'(1) << idx;
      end
      return '0;
   endfunction

   // One clock: check all outputs against the model, advance the model, cross the edge.
   task automatic tick();
      logic [NREQ-1:0] g;
      logic [NREQ-1:0] erv;
      bit              fire;
      int              id;
      ent_t            e;
      #1;
      g   = model_grant();
      erv = '0;
      if (q.size() > 0 && q[0].vis) erv = NREQ'(1) << q[0].id;
      chk("m_req_ready", o_req_ready, g);
      chk("m_rsp_valid", o_rsp_valid, erv);
      chk("m_busy", o_busy, q.size() != 0);
      if (erv != '0) chk("m_rsp_res", o_rsp_res, q[0].res);
      acc_vec = '0;
      if (rst) begin
         q.delete();
         last_m = NREQ - 1;
      end else begin
         fire = (q.size() > 0) && q[0].vis && i_rsp_ready[q[0].id];
         if (fire) void'(q.pop_front());
         if (q.size() > 0 && !q[0].vis) begin
            e     = q.pop_front();
            e.vis = 1'b1;
            q.push_front(e);
         end
         if (g != '0) begin
            id = 0;
            for (int r = 0; r < NREQ; r++) if (g[r]) id = r;
            e.id  = id;
            e.res = arr_fn(op_r[id], i_req_in1[id*DW +: DW], i_req_in2[id*DW +: DW]);
            e.vis = 1'b0;
            q.push_back(e);
            last_m  = id;
            acc_vec = g;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_data();
      for (int r = 0; r < NREQ; r++) begin
         op_r[r] = 2'd0;
         for (int k = 0; k < 5; k++) begin
            in1_r[r][k] = '0;
            in2_r[r][k] = '0;
         end
      end
   endtask

   // Requester r: add, in1 = {d0, 2..5} + 100r, in2 = {10,20,30,40,50}; word0 result = d0+100r+10.
   task automatic set_tbl_data(input logic [31:0] d0);
      for (int r = 0; r < NREQ; r++) begin
         op_r[r] = 2'd0;
         for (int k = 0; k < 5; k++) begin
            in1_r[r][k] = (k == 0 ? d0 : 32'(k + 1)) + 32'(100 * r);
            in2_r[r][k] = 32'(10 * (k + 1));
         end
      end
   endtask

   typedef struct {
      logic [NREQ-1:0] req_v;
      logic [NREQ-1:0] rsp_k;
      logic [31:0]     d0;
      logic [NREQ-1:0] e_rdy;
      logic [NREQ-1:0] e_rv;
      logic            e_busy;
      logic [31:0]     e_res0;
   } vec_t;

   vec_t tbl [19];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0]   exp_add;
      logic [NREQ-1:0] pend;

      exp_add = {32'd55, 32'd44, 32'd33, 32'd22, 32'd11};

      // Round-robin after reset, drain, then r1 streaming into a stalled response stage.
      tbl[0]  = '{4'b0000, 4'b1111, 32'd1, 4'b0000, 4'b0000, 1'b0, 32'd0};
      tbl[1]  = '{4'b1111, 4'b1111, 32'd1, 4'b0001, 4'b0000, 1'b0, 32'd0};
      tbl[2]  = '{4'b1111, 4'b1111, 32'd1, 4'b0010, 4'b0000, 1'b1, 32'd0};
      tbl[3]  = '{4'b1111, 4'b1111, 32'd1, 4'b0100, 4'b0001, 1'b1, 32'd11};
      tbl[4]  = '{4'b1111, 4'b1111, 32'd1, 4'b1000, 4'b0010, 1'b1, 32'd111};
      tbl[5]  = '{4'b1111, 4'b1111, 32'd1, 4'b0001, 4'b0100, 1'b1, 32'd211};
      tbl[6]  = '{4'b1111, 4'b1111, 32'd1, 4'b0010, 4'b1000, 1'b1, 32'd311};
      tbl[7]  = '{4'b0000, 4'b1111, 32'd1, 4'b0000, 4'b0001, 1'b1, 32'd11};
      tbl[8]  = '{4'b0000, 4'b1111, 32'd1, 4'b0000, 4'b0010, 1'b1, 32'd111};
      tbl[9]  = '{4'b0000, 4'b1111, 32'd1, 4'b0000, 4'b0000, 1'b0, 32'd0};
      tbl[10] = '{4'b0010, 4'b0000, 32'd1, 4'b0010, 4'b0000, 1'b0, 32'd0};
      tbl[11] = '{4'b0010, 4'b0000, 32'd2, 4'b0010, 4'b0000, 1'b1, 32'd0};
      tbl[12] = '{4'b0010, 4'b0000, 32'd3, 4'b0000, 4'b0010, 1'b1, 32'd111};
      tbl[13] = '{4'b0010, 4'b1101, 32'd3, 4'b0000, 4'b0010, 1'b1, 32'd111};
      tbl[14] = '{4'b0010, 4'b0000, 32'd3, 4'b0000, 4'b0010, 1'b1, 32'd111};
      tbl[15] = '{4'b0010, 4'b1111, 32'd3, 4'b0010, 4'b0010, 1'b1, 32'd111};
      tbl[16] = '{4'b0000, 4'b1111, 32'd3, 4'b0000, 4'b0010, 1'b1, 32'd112};
      tbl[17] = '{4'b0000, 4'b1111, 32'd3, 4'b0000, 4'b0010, 1'b1, 32'd113};
      tbl[18] = '{4'b0000, 4'b1111, 32'd3, 4'b0000, 4'b0000, 1'b0, 32'd0};

      rst         = 1'b1;
      i_req_valid = '0;
      i_rsp_ready = '0;
      clear_data();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         i_req_valid = tbl[i].req_v;
         i_rsp_ready = tbl[i].rsp_k;
         set_tbl_data(tbl[i].d0);
         #1;
         if (i == 0) begin
            chk("reset_arr_opcode", o_arr_opcode, 2'd0);
            chk("reset_arr_in1", o_arr_in1, '0);
            chk("reset_arr_in2", o_arr_in2, '0);
            chk("reset_rsp_res", o_rsp_res, '0);
         end
         chk($sformatf("tbl%0d_req_ready", i), o_req_ready, tbl[i].e_rdy);
         chk($sformatf("tbl%0d_rsp_valid", i), o_rsp_valid, tbl[i].e_rv);
         chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].e_busy);
         if (tbl[i].e_rv != '0) chk($sformatf("tbl%0d_res0", i), o_rsp_res[31:0], tbl[i].e_res0);
         if (i == 3) chk("add_vector", o_rsp_res, exp_add);
         tick();
      end

      // Sub wrap-around from r0.
      clear_data();
      op_r[0]     = 2'd1;
      in2_r[0][0] = 32'd1;
      i_req_valid = 4'b0001;
      i_rsp_ready = 4'b1111;
      tick();
      i_req_valid = '0;
      chk("sub_arr_opcode", o_arr_opcode, 2'd1);
      chk("sub_arr_in2", o_arr_in2, DW'(1));
      tick();
      chk("sub_rsp_valid", o_rsp_valid, 4'b0001);
      chk("sub_wrap", o_rsp_res[31:0], 32'hFFFF_FFFF);
      tick();

      // Matmul from r2, then opcode 3 from r3 which the array treats as matmul.
      for (int k = 0; k < 5; k++) begin
         in1_r[2][k] = 32'(k + 1);
         in1_r[3][k] = 32'(k + 1);
      end
      in2_r[2][0] = 32'd1; in2_r[2][1] = 32'd1; in2_r[2][2] = 32'd1;
      in2_r[2][3] = 32'd7; in2_r[2][4] = 32'd9;
      for (int k = 0; k < 5; k++) in2_r[3][k] = in2_r[2][k];
      op_r[2] = 2'd2;
      op_r[3] = 2'd3;
      i_req_valid = 4'b0100;
      tick();
      i_req_valid = '0;
      tick();
      chk("mm_rsp_valid", o_rsp_valid, 4'b0100);
      chk("mm_word0", o_rsp_res[31:0], 32'd6);
      chk("mm_word1", o_rsp_res[63:32], 32'd9);
      chk("mm_word2", o_rsp_res[95:64], 32'd12);
      tick();
      i_req_valid = 4'b1000;
      tick();
      i_req_valid = '0;
      chk("op3_forwarded", o_arr_opcode, 2'd3);
      tick();
      chk("op3_rsp_valid", o_rsp_valid, 4'b1000);
      chk("op3_word0", o_rsp_res[31:0], 32'd6);
      tick();

      // Reset with both stages full.
      set_tbl_data(32'd5);
      i_rsp_ready = '0;
      i_req_valid = 4'b0011;
      tick();
      tick();
      chk("full_busy", o_busy, 1'b1);
      chk("full_no_ready", o_req_ready, '0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_rsp_valid", o_rsp_valid, '0);
      chk("rst_first_grant", o_req_ready, 4'b0001);
      tick();
      i_req_valid = '0;
      i_rsp_ready = 4'b1111;
      repeat (3) tick();

      // Random traffic with holds, drops, backpressure and one reset pulse.
      pend    = '0;
      acc_vec = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int r = 0; r < NREQ; r++) begin
            if (acc_vec[r]) pend[r] = 1'b0;
            if (pend[r] && $urandom_range(0, 15) == 0) pend[r] = 1'b0;
            if (!pend[r] && $urandom_range(0, 1) == 1) begin
               pend[r] = 1'b1;
               op_r[r] = 2'($urandom_range(0, 3));
               for (int k = 0; k < 5; k++) begin
                  in1_r[r][k] = $urandom();
                  in2_r[r][k] = $urandom();
               end
            end
            i_rsp_ready[r] = ($urandom_range(0, 9) < 7);
         end
         i_req_valid = pend;
         rst = (cyc == 300);
         tick();
      end
      rst         = 1'b0;
      i_req_valid = '0;
      i_rsp_ready = 4'b1111;
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/array_arbiter.md
# array_arbiter

Round-robin arbiter and two-stage pipeline wrapper that shares one combinational `array` unit between `NREQ` requesters (SIMD lanes/cores). It accepts one add/sub/matmul command per cycle from the winning requester and registers the operands into an issue stage. The `array` result is captured into a response stage and returned to the owning requester with a valid/ready handshake.

## Interface
Parameters:
- `UNIT_SIZE`, 32: element width; operands and results are 5 elements wide.
- `NREQ`, 4: number of requesters, 2..8.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_req_valid`  in  NREQ  per-requester command valid.
- `o_req_ready`  out  NREQ  one-hot grant; command accepted when valid&ready.
- `i_req_opcode`  in  2*NREQ  opcode of requester r at [2r+:2]; 0 add, 1 sub, 2 matmul.
- `i_req_in1`  in  NREQ*5*UNIT_SIZE  operand 1 of requester r at [r*5*UNIT_SIZE+:5*UNIT_SIZE].
- `i_req_in2`  in  NREQ*5*UNIT_SIZE  operand 2, same packing.
- `o_rsp_valid`  out  NREQ  one-hot; result available for requester r.
- `i_rsp_ready`  in  NREQ  requester r consumes result.
- `o_rsp_res`  out  5*UNIT_SIZE  result, shared bus; meaningful only while some `o_rsp_valid` bit is set.
- `o_arr_opcode`  out  2  to `array.opcode`.
- `o_arr_in1`, `o_arr_in2`  out  5*UNIT_SIZE  to `array.i_in1` and `array.i_in2`.
- `i_arr_res`  in  5*UNIT_SIZE  from `array.o_res`.
- `o_busy`  out  1  either pipeline stage valid.

## Operation
- Issue stage (S1): `s1_valid`, `s1_id` (log2 NREQ), and registered opcode/in1/in2, which drive `o_arr_*` directly.
- Response stage (S2): `s2_valid`, `s2_id`, and `s2_res` captured from `i_arr_res`.
- `o_rsp_valid = s2_valid ? onehot(s2_id) : 0`. `o_rsp_res = s2_res`.
- Drain: `s2_fire = s2_valid & i_rsp_ready[s2_id]`.
- S2 load enable: `s2_en = !s2_valid | s2_fire`. When enabled, S2 takes `s1_valid/s1_id/i_arr_res`.
- S1 load enable: `s1_en = !s1_valid | s2_en`. When enabled, S1 takes the grant; it is cleared if there is no grant.
- Arbitration (combinational): when `s1_en`, grant the first valid requester searching from `last+1` upward with wrap. `o_req_ready` is the one-hot grant, or 0 when `!s1_en` or there are no requests.
- `last` updates to the granted index only on an accepted command.
- Opcode is forwarded unmodified. Opcode 3 is not rejected; `array` executes it as matmul.
- Operand and result data are passed bit-exact. No width change and no saturation: wrap-around arithmetic is `array`'s.
- `o_busy = s1_valid | s2_valid`.
- Requesters must hold valid/data stable until accepted. A requester may drop valid without penalty.

## Timing
- Reset values: `s1_valid=0`, `s2_valid=0`, `last=NREQ-1` (requester 0 wins first), data registers 0.
- Reset outputs: `o_req_ready=0`, `o_rsp_valid=0`, `o_busy=0`, `o_arr_opcode=0`, `o_arr_in1=0`, `o_arr_in2=0`, `o_rsp_res=0`.
- Latency: a command accepted at cycle T shows `o_rsp_valid` at T+2.
- Throughput: 1 command/cycle with `i_rsp_ready` held high.
- Backpressure: S2 stall holds S1; with both stages full, `o_req_ready=0`.
- Same-cycle drain: drain and accept in the same cycle is allowed. A full pipeline with `s2_fire` accepts a new command that cycle (no bubble).
- `rst` mid-operation: in-flight commands are discarded with no response. The arbiter pointer returns to its reset value.
- `i_rsp_ready` bits of non-owners are ignored.

## Test plan
- Single add: r0 issues opcode 0, in1 words {1,2,3,4,5}, in2 {10,20,30,40,50} at T -> `o_rsp_valid=0001` at T+2, `o_rsp_res={11,22,33,44,55}`.
- Matmul: r2 issues opcode 2, in1 elements {1..5}, in2 vec {1,1,1,x,x} -> result words 0..2 equal to the row sums computed by the array model, `o_rsp_valid=0100`.
- Round-robin: all 4 requesters valid continuously with ready high -> grants 0,1,2,3,0,1 on consecutive cycles. Responses come back in the same order, one per cycle.
- Backpressure: `i_rsp_ready=0` for 5 cycles with r1 streaming -> exactly 2 accepted, then `o_req_ready=0`. When ready rises, one response drains per cycle with no loss, duplication or reorder.
- Sub wrap: UNIT_SIZE=32, in1 word 0 = 0, in2 word 0 = 1, opcode 1 -> result word 0 = 0xFFFFFFFF.
- Reset mid-flight: assert `rst` with both stages full -> next cycle `o_busy=0`, no `o_rsp_valid`. First grant after reset goes to r0.
